// File: rtl/wave_dac_serializer_if.sv
// Three-wire serial DAC link. The serializer drives it (master); the DAC receives it (slave).
interface wave_dac_serializer_if;
  logic dac_cs_n;
  logic dac_sclk;
  logic dac_mosi;

  modport master (output dac_cs_n, dac_sclk, dac_mosi);
  modport slave  (input  dac_cs_n, dac_sclk, dac_mosi);
endinterface

// File: rtl/wave_dac_serializer.sv
// Captures an 8-bit sample every SAMPLE_DIV cycles and shifts it MSB-first to a serial DAC in 17*CLK_DIV cycles.
// There is no backpressure: a tick that arrives while a frame is still in progress is dropped and sets sticky overrun.
module wave_dac_serializer #(
  parameter int CLK_DIV    = 2,
  parameter int SAMPLE_DIV = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [7:0]                   sample_in,
  wave_dac_serializer_if.master        dac,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int HC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [HC_W-1:0]  hc;
  logic [2:0]       bit_idx;
  // Only bits 6..0 are kept; bit 7 goes straight to dac_mosi at capture.
  logic [6:0]       shift_reg;
  logic             tick;
  logic             phase_end;

  assign tick      = enable && (cnt == CNT_LAST);
  assign phase_end = (hc == HC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!enable || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      hc           <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      dac.dac_cs_n <= 1'b1;
      dac.dac_sclk <= 1'b0;
      dac.dac_mosi <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tick) begin
            shift_reg    <= sample_in[6:0];
            dac.dac_mosi <= sample_in[7];
            dac.dac_cs_n <= 1'b0;
            busy         <= 1'b1;
            hc           <= '0;
            bit_idx      <= '0;
            state        <= SETUP;
          end
        end

        SETUP: begin
          if (phase_end) begin
            hc           <= '0;
            dac.dac_sclk <= 1'b1;
            state        <= SHIFT;
          end else begin
            hc <= hc + HC_W'(1);
          end
        end

        SHIFT: begin
          if (phase_end) begin
            hc           <= '0;
            dac.dac_sclk <= ~dac.dac_sclk;
            // Data moves only on the falling edge so it is settled a full half-period before the DAC samples it.
            if (dac.dac_sclk) begin
              if (bit_idx != 3'd7) begin
                dac.dac_mosi <= shift_reg[6];
                shift_reg    <= {shift_reg[5:0], 1'b0};
                bit_idx      <= bit_idx + 3'd1;
              end else begin
                state <= HOLD;
              end
            end
          end else begin
            hc <= hc + HC_W'(1);
          end
        end

        HOLD: begin
          if (phase_end) begin
            hc           <= '0;
            dac.dac_cs_n <= 1'b1;
            dac.dac_mosi <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b1;
            state        <= IDLE;
          end else begin
            hc <= hc + HC_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_dac_serializer.sv
// Directed bench for wave_dac_serializer: three instances cover the default rates, an overrunning rate and CLK_DIV=1.
module tb_wave_dac_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic       rst0_n = 1'b0, en0 = 1'b0;
  logic [7:0] smp0 = 8'h00;
  logic       busy0, fd0, ov0;
  wave_dac_serializer_if if0();

  logic       rst1_n = 1'b0, en1 = 1'b0;
  logic [7:0] smp1 = 8'h5A;
  logic       busy1, fd1, ov1;
  wave_dac_serializer_if if1();

  logic       rst2_n = 1'b0, en2 = 1'b0;
  logic [7:0] smp2 = 8'h00;
  logic       busy2, fd2, ov2;
  wave_dac_serializer_if if2();

  wave_dac_serializer #(.CLK_DIV(2), .SAMPLE_DIV(64)) u_dut0 (
    .clk(clk), .reset(rst0_n), .enable(en0), .sample_in(smp0), .dac(if0),
    .busy(busy0), .frame_done(fd0), .overrun(ov0));

  wave_dac_serializer #(.CLK_DIV(2), .SAMPLE_DIV(20)) u_dut1 (
    .clk(clk), .reset(rst1_n), .enable(en1), .sample_in(smp1), .dac(if1),
    .busy(busy1), .frame_done(fd1), .overrun(ov1));

  wave_dac_serializer #(.CLK_DIV(1), .SAMPLE_DIV(18)) u_dut2 (
    .clk(clk), .reset(rst2_n), .enable(en2), .sample_in(smp2), .dac(if2),
    .busy(busy2), .frame_done(fd2), .overrun(ov2));

  // Frame observer for instance 0, sampled on the falling clock edge.
  int         m0_falls = 0, m0_ends = 0, m0_fall_cyc = 0, m0_low_run = 0;
  int         m0_frame_rises = 0, m0_rise_first = 0, m0_rise_last = 0, m0_fd_total = 0;
  logic [7:0] m0_bits = 8'h00;
  logic       m0_fd_at_end = 1'b0, m0_cs_q = 1'b1, m0_sclk_q = 1'b0;

  always @(negedge clk) begin
    if (m0_cs_q && (if0.dac_cs_n === 1'b0)) begin
      m0_falls++;
      m0_fall_cyc    = cyc;
      m0_low_run     = 0;
      m0_frame_rises = 0;
      m0_bits        = 8'h00;
    end
    if (if0.dac_cs_n === 1'b0) m0_low_run++;
    if (!m0_sclk_q && (if0.dac_sclk === 1'b1)) begin
      if (m0_frame_rises == 0) m0_rise_first = cyc - m0_fall_cyc;
      m0_rise_last = cyc - m0_fall_cyc;
      m0_bits      = {m0_bits[6:0], if0.dac_mosi};
      m0_frame_rises++;
    end
    if (!m0_cs_q && (if0.dac_cs_n === 1'b1)) begin
      m0_ends++;
      m0_fd_at_end = fd0;
    end
    if (fd0 === 1'b1) m0_fd_total++;
    m0_cs_q   = (if0.dac_cs_n !== 1'b0);
    m0_sclk_q = (if0.dac_sclk === 1'b1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_falls0(input int target, input int budget, output bit ok);
    int n = 0;
    while (m0_falls < target && n < budget) begin step(); n++; end
    ok = (m0_falls >= target);
  endtask

  task automatic wait_ends0(input int target, input int budget, output bit ok);
    int n = 0;
    while (m0_ends < target && n < budget) begin step(); n++; end
    ok = (m0_ends >= target);
  endtask

  task automatic wait_rises0(input int target, input int budget, output bit ok);
    int n = 0;
    while (m0_frame_rises < target && n < budget) begin step(); n++; end
    ok = (m0_frame_rises >= target);
  endtask

  task automatic test_reset();
    rst0_n = 1'b0;
    en0    = 1'b0;
    repeat (3) step();
    checks++; if (if0.dac_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", if0.dac_cs_n); end
    checks++; if (if0.dac_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", if0.dac_sclk); end
    checks++; if (if0.dac_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", if0.dac_mosi); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
    checks++; if (fd0 !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", fd0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", ov0); end
    rst0_n = 1'b1;
    step();
  endtask

  task automatic test_full_scale();
    int c, f, e, fd;
    bit ok;
    smp0 = 8'd255;
    f = m0_falls; e = m0_ends; fd = m0_fd_total;
    en0 = 1'b1;
    c = cyc;
    wait_falls0(f + 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_fall_timeout: falls %0d want %0d", m0_falls, f + 1); end
    checks++; if (m0_fall_cyc !== c + 64) begin errors++; $display("FAIL full_capture_latency: fell at %0d want %0d", m0_fall_cyc - c, 64); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL full_busy: got %b want 1", busy0); end
    wait_ends0(e + 1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_end_timeout: ends %0d want %0d", m0_ends, e + 1); end
    checks++; if (m0_low_run !== 34) begin errors++; $display("FAIL full_cs_low_len: got %0d want 34", m0_low_run); end
    checks++; if (m0_frame_rises !== 8) begin errors++; $display("FAIL full_sclk_rises: got %0d want 8", m0_frame_rises); end
    checks++; if (m0_bits !== 8'hFF) begin errors++; $display("FAIL full_bits: got %h want ff", m0_bits); end
    checks++; if (m0_rise_first !== 2) begin errors++; $display("FAIL full_first_rise: got %0d want 2", m0_rise_first); end
    checks++; if (m0_rise_last !== 30) begin errors++; $display("FAIL full_last_rise: got %0d want 30", m0_rise_last); end
    checks++; if (m0_fd_total - fd !== 1) begin errors++; $display("FAIL full_fd_count: got %0d want 1", m0_fd_total - fd); end
    checks++; if (m0_fd_at_end !== 1'b1) begin errors++; $display("FAIL full_fd_align: got %b want 1", m0_fd_at_end); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL full_overrun: got %b want 0", ov0); end
  endtask

  task automatic test_pattern_a5();
    int f, e, prev;
    bit ok;
    smp0 = 8'hA5;
    f = m0_falls; e = m0_ends; prev = m0_fall_cyc;
    wait_falls0(f + 1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL a5_fall_timeout: falls %0d want %0d", m0_falls, f + 1); end
    checks++; if (m0_fall_cyc - prev !== 64) begin errors++; $display("FAIL a5_frame_spacing: got %0d want 64", m0_fall_cyc - prev); end
    smp0 = 8'h00;
    wait_ends0(e + 1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL a5_end_timeout: ends %0d want %0d", m0_ends, e + 1); end
    checks++; if (m0_bits !== 8'hA5) begin errors++; $display("FAIL a5_bits: got %h want a5", m0_bits); end
    checks++; if (m0_frame_rises !== 8) begin errors++; $display("FAIL a5_sclk_rises: got %0d want 8", m0_frame_rises); end
    checks++; if (m0_fd_at_end !== 1'b1) begin errors++; $display("FAIL a5_fd_align: got %b want 1", m0_fd_at_end); end
  endtask

  task automatic test_reset_mid_frame();
    int c, f, fd;
    bit ok;
    smp0 = 8'h3C;
    f = m0_falls;
    wait_falls0(f + 1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_fall_timeout: falls %0d want %0d", m0_falls, f + 1); end
    wait_rises0(3, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_rise_timeout: rises %0d want 3", m0_frame_rises); end
    fd = m0_fd_total;
    rst0_n = 1'b0;
    #1;
    checks++; if (if0.dac_cs_n !== 1'b1) begin errors++; $display("FAIL rstmid_cs_n: got %b want 1", if0.dac_cs_n); end
    checks++; if (if0.dac_sclk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk: got %b want 0", if0.dac_sclk); end
    checks++; if (if0.dac_mosi !== 1'b0) begin errors++; $display("FAIL rstmid_mosi: got %b want 0", if0.dac_mosi); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
    repeat (2) step();
    checks++; if (m0_fd_total !== fd) begin errors++; $display("FAIL rstmid_no_fd: got %0d pulses want %0d", m0_fd_total, fd); end
    checks++; if (m0_fd_at_end !== 1'b0) begin errors++; $display("FAIL rstmid_fd_at_abort: got %b want 0", m0_fd_at_end); end
    rst0_n = 1'b1;
    c = cyc;
    f = m0_falls;
    wait_falls0(f + 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_restart_timeout: falls %0d want %0d", m0_falls, f + 1); end
    checks++; if (m0_fall_cyc !== c + 64) begin errors++; $display("FAIL rstmid_restart_latency: got %0d want 64", m0_fall_cyc - c); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b want 0", ov0); end
  endtask

  task automatic test_enable_drop();
    int c, f, e, fd;
    bit ok;
    f = m0_falls; e = m0_ends; fd = m0_fd_total;
    wait_rises0(2, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL endrop_rise_timeout: rises %0d want 2", m0_frame_rises); end
    en0 = 1'b0;
    wait_ends0(e + 1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL endrop_end_timeout: ends %0d want %0d", m0_ends, e + 1); end
    checks++; if (m0_frame_rises !== 8) begin errors++; $display("FAIL endrop_sclk_rises: got %0d want 8", m0_frame_rises); end
    checks++; if (m0_bits !== 8'h3C) begin errors++; $display("FAIL endrop_bits: got %h want 3c", m0_bits); end
    checks++; if (m0_fd_total - fd !== 1) begin errors++; $display("FAIL endrop_fd_count: got %0d want 1", m0_fd_total - fd); end
    repeat (100) step();
    checks++; if (m0_falls !== f) begin errors++; $display("FAIL endrop_no_new_frame: falls %0d want %0d", m0_falls, f); end
    en0 = 1'b1;
    c = cyc;
    wait_falls0(f + 1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL endrop_restart_timeout: falls %0d want %0d", m0_falls, f + 1); end
    checks++; if (m0_fall_cyc !== c + 64) begin errors++; $display("FAIL endrop_restart_latency: got %0d want 64", m0_fall_cyc - c); end
    en0 = 1'b0;
    wait_ends0(e + 2, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL endrop_final_end_timeout: ends %0d want %0d", m0_ends, e + 2); end
  endtask

  task automatic test_overrun();
    int c;
    int nf = 0;
    int fall_at [4];
    logic csq = 1'b1;
    rst1_n = 1'b1;
    step();
    en1 = 1'b1;
    c = cyc;
    for (int i = 1; i <= 110; i++) begin
      step();
      if (csq && (if1.dac_cs_n === 1'b0)) begin
        if (nf < 4) fall_at[nf] = cyc - c;
        nf++;
      end
      csq = (if1.dac_cs_n !== 1'b0);
      if (i == 39) begin
        checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL ovr_before_drop: got %b want 0", ov1); end
      end
      if (i == 40) begin
        checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL ovr_at_drop: got %b want 1", ov1); end
      end
    end
    checks++; if (nf !== 3) begin errors++; $display("FAIL ovr_frame_count: got %0d want 3", nf); end
    checks++; if (fall_at[0] !== 20) begin errors++; $display("FAIL ovr_first_frame: got %0d want 20", fall_at[0]); end
    checks++; if (fall_at[1] !== 60) begin errors++; $display("FAIL ovr_second_frame: got %0d want 60", fall_at[1]); end
    checks++; if (fall_at[2] !== 100) begin errors++; $display("FAIL ovr_third_frame: got %0d want 100", fall_at[2]); end
    checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", ov1); end
    en1 = 1'b0;
  endtask

  task automatic test_square_div1();
    int c;
    int nf = 0, prev_fall = 0, low = 0, rises = 0;
    logic csq = 1'b1, sclkq = 1'b0;
    logic [7:0] bits = 8'h00, exp_cap = 8'h00;
    rst2_n = 1'b1;
    smp2 = 8'h00;
    step();
    en2 = 1'b1;
    c = cyc;
    for (int i = 1; i <= 120; i++) begin
      step();
      if (csq && (if2.dac_cs_n === 1'b0)) begin
        if (nf == 0) begin
          checks++; if (cyc - c !== 18) begin errors++; $display("FAIL sq_first_latency: got %0d want 18", cyc - c); end
        end else begin
          checks++; if (cyc - prev_fall !== 18) begin errors++; $display("FAIL sq_spacing: got %0d want 18", cyc - prev_fall); end
        end
        prev_fall = cyc;
        nf++;
        exp_cap = smp2;
        low = 0; rises = 0; bits = 8'h00;
      end
      if (if2.dac_cs_n === 1'b0) low++;
      if (!sclkq && (if2.dac_sclk === 1'b1)) begin
        bits = {bits[6:0], if2.dac_mosi};
        rises++;
      end
      if (!csq && (if2.dac_cs_n === 1'b1)) begin
        checks++; if (low !== 17) begin errors++; $display("FAIL sq_cs_low_len: got %0d want 17", low); end
        checks++; if (rises !== 8) begin errors++; $display("FAIL sq_sclk_rises: got %0d want 8", rises); end
        checks++; if (bits !== exp_cap) begin errors++; $display("FAIL sq_bits: got %h want %h", bits, exp_cap); end
        checks++; if (fd2 !== 1'b1) begin errors++; $display("FAIL sq_fd_align: got %b want 1", fd2); end
      end
      csq   = (if2.dac_cs_n !== 1'b0);
      sclkq = (if2.dac_sclk === 1'b1);
      if (i % 5 == 0) smp2 = ~smp2;
    end
    checks++; if (nf !== 6) begin errors++; $display("FAIL sq_frame_count: got %0d want 6", nf); end
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL sq_overrun: got %b want 0", ov2); end
    en2 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_scale();
    test_pattern_a5();
    test_reset_mid_frame();
    test_enable_drop();
    test_overrun();
    test_square_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_dac_serializer.md
# wave_dac_serializer

Downstream consumer of the 8-bit waveform generators (square wave and siblings). At a programmable sample rate it captures the generator's 8-bit output and shifts it MSB-first to an external 8-bit serial DAC over a 3-wire SPI-style link (chip-select, clock, data). It also reports per-frame completion and sticky sample overrun.

## Interface
- CLK_DIV, default 2: length of each DAC clock half-period, in clk cycles. Must be ≥ 1.
- SAMPLE_DIV, default 64: number of clk cycles per sample tick. Must be ≥ 2.
- clk  input  1  System clock. All logic runs on the rising edge.
- reset  input  1  Asynchronous, active-low reset. 0 resets the block; 1 runs it.
- enable  input  1  1 lets the sample counter run. 0 holds the counter at 0.
- sample_in  input  8  Waveform sample from the upstream generator (wave_out).
- dac_cs_n  output  1  DAC chip select, active-low.
- dac_sclk  output  1  DAC serial clock. Idles low; the DAC samples dac_mosi on its rising edge.
- dac_mosi  output  1  Serial data, MSB first.
- busy  output  1  High while a frame is in progress. Equals ~dac_cs_n.
- frame_done  output  1  One-cycle pulse when a frame completes.
- overrun  output  1  Sticky flag, set when a tick is dropped. Cleared only by reset.

## Operation
- Reset (reset=0, asynchronous): state=IDLE, sample counter=0, dac_cs_n=1, dac_sclk=0, dac_mosi=0, busy=0, frame_done=0, overrun=0. Reset mid-frame aborts the frame immediately; no partial completion and no frame_done.
- Sample counter:
  - Counts 0..SAMPLE_DIV-1 while enable=1, then wraps to 0.
  - tick is asserted (internal, combinational) when enable=1 and count==SAMPLE_DIV-1.
  - enable=0 clears the counter to 0 on the next edge; any frame in progress still completes.
- FSM states: IDLE, SETUP, SHIFT, HOLD. A half-period counter hc counts 0..CLK_DIV-1 and marks each phase end at hc==CLK_DIV-1.
  - IDLE, on tick: shift_reg←sample_in, dac_mosi←sample_in[7], dac_cs_n←0, go to SETUP. hc=0, bit index=0.
  - SETUP: dac_sclk=0 for CLK_DIV cycles, then dac_sclk←1 and go to SHIFT.
  - SHIFT, each bit:
    - dac_sclk high for CLK_DIV cycles.
    - At the falling transition (sclk←0), if bit index<7: shift, dac_mosi←next bit, stay low for CLK_DIV cycles, then sclk←1 for the next bit.
    - At the falling transition after bit 7: go to HOLD.
  - HOLD: dac_sclk=0, dac_mosi holds bit 0, for CLK_DIV cycles. On the last HOLD edge: dac_cs_n←1, dac_mosi←0, frame_done←1 for one cycle, go to IDLE.
- Data integrity: sample_in changes after capture have no effect on the frame in progress.
- Overrun: a tick while state≠IDLE (including the final HOLD cycle) is dropped and overrun←1. The counter keeps running regardless.

## Timing
- All outputs are registered; no combinational paths from inputs to outputs.
- Capture latency: dac_cs_n falls on the same edge that samples tick, i.e. SAMPLE_DIV cycles after enable is first sampled high (counter starting from 0).
- Frame length: dac_cs_n is low for exactly 17·CLK_DIV cycles (SETUP CLK_DIV, then 8×(high CLK_DIV + low CLK_DIV)). Exactly 8 rising edges of dac_sclk per frame.
- Rising edge k (k=0..7) of dac_sclk occurs CLK_DIV·(1+2k) cycles after dac_cs_n falls, with dac_mosi = sample bit 7−k. dac_mosi is stable from CLK_DIV cycles before each rising edge until CLK_DIV cycles after it.
- frame_done is high in the cycle where dac_cs_n first reads 1 again.
- Overrun-free condition: SAMPLE_DIV > 17·CLK_DIV. Under this condition each tick produces exactly one frame, and frames start SAMPLE_DIV cycles apart.

## Test plan
- CLK_DIV=2, SAMPLE_DIV=64, sample_in=8'd255, enable=1 → dac_cs_n falls at cycle 64 and stays low 34 cycles. All 8 sclk rising edges see mosi=1. frame_done pulses once. overrun=0.
- sample_in=8'hA5 → bits sampled on sclk rising edges are 1,0,1,0,0,1,0,1. Changing sample_in to 8'h00 after capture does not alter the frame.
- SAMPLE_DIV=20, CLK_DIV=2 (frame 34 > 20) → every second tick is dropped, overrun=1 from the first dropped tick, frame starts 40 cycles apart.
- Reset pulled to 0 at the 3rd sclk rising edge → immediately dac_cs_n=1, dac_sclk=0, dac_mosi=0, busy=0, no frame_done. After release, the next frame starts SAMPLE_DIV cycles later.
- enable dropped mid-frame → the frame completes with all 8 bits and frame_done. No new frame starts until enable has been high again for SAMPLE_DIV cycles.
- CLK_DIV=1, SAMPLE_DIV=18, upstream square generator attached → a frame every 18 cycles, dac_cs_n low 17 cycles, overrun=0. Each captured value is 8'd0 or 8'd255, matching sample_in at the capture edge.
